// File: rtl/div_pkg.sv
// div_pkg: op and state encodings shared by the divide unit
package div_pkg;
    localparam logic [1:0] DIV_OP  = 2'b00;
    localparam logic [1:0] DIVU_OP = 2'b01;
    localparam logic [1:0] REM_OP  = 2'b10;
    localparam logic [1:0] REMU_OP = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {
        OP_DIV  = DIV_OP,
        OP_DIVU = DIVU_OP,
        OP_REM  = REM_OP,
        OP_REMU = REMU_OP
    } div_op_e;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_q
);
    logic [W:0]   w_shift;
    logic [W-1:0] w_sub;
    assign w_shift = {i_rem, i_bit};
    assign w_sub   = w_shift[W-1:0] - i_divisor;
    assign o_q     = w_shift >= {1'b0, i_divisor};
    assign o_rem   = o_q ? w_sub : w_shift[W-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU with single-cycle corner-case paths
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_kill,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    div_state_e          r_state;
    div_op_e             r_op;
    logic [W-1:0]        r_quot;
    logic [W-1:0]        r_rem;
    logic [W-1:0]        r_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [CW-1:0]       r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                r_valid;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [W-1:0]        r_rd_data;
    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [W-1:0]        w_a_abs;
    logic [W-1:0]        w_b_abs;
    logic                w_div0;
    logic                w_ovf;
    logic                w_accept;
    logic [W-1:0]        w_rem_nxt;
    logic                w_q_bit;
    logic [W-1:0]        w_q_fix;
    logic [W-1:0]        w_r_fix;
    assign w_signed = (i_op == DIV_OP) || (i_op == REM_OP);
    assign w_a_neg  = w_signed & i_rs1_data[W-1];
    assign w_b_neg  = w_signed & i_rs2_data[W-1];
    assign w_a_abs  = w_a_neg ? -i_rs1_data : i_rs1_data;
    assign w_b_abs  = w_b_neg ? -i_rs2_data : i_rs2_data;
    assign w_div0   = i_rs2_data == '0;
    assign w_ovf    = w_signed && (i_rs1_data == {1'b1, {(W-1){1'b0}}}) && (&i_rs2_data);
    assign o_ready  = (r_state == S_IDLE) && !r_valid && !i_rst;
    assign w_accept = o_ready && i_valid && !i_kill;
    assign w_q_fix  = r_neg_q ? -r_quot : r_quot;
    assign w_r_fix  = r_neg_r ? -r_rem : r_rem;
    assign o_valid   = r_valid;
    assign o_rd_addr = r_rd_addr;
    assign o_rd_data = r_rd_data;
    div_step #(.W(W)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quot[W-1]),
        .i_divisor (r_div),
        .o_rem     (w_rem_nxt),
        .o_q       (w_q_bit)
    );
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_op      <= OP_DIV;
            r_quot    <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_valid   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            r_valid <= 1'b0;
            if (i_kill) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (w_accept) begin
                        r_op    <= div_op_e'(i_op);
                        r_addr  <= i_rd_addr;
                        r_cnt   <= '0;
                        r_div   <= w_b_abs;
                        r_neg_q <= !w_div0 && !w_ovf && (w_a_neg ^ w_b_neg);
                        r_neg_r <= !w_div0 && !w_ovf && w_a_neg;
                        r_quot  <= w_div0 ? '1 : w_ovf ? {1'b1, {(W-1){1'b0}}} : w_a_abs;
                        r_rem   <= w_div0 ? i_rs1_data : '0;
                        r_state <= (w_div0 || w_ovf) ? S_DONE : S_CALC;
                    end
                    S_CALC: begin
                        r_rem   <= w_rem_nxt;
                        r_quot  <= {r_quot[W-2:0], w_q_bit};
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= (r_cnt == CW'(W - 1)) ? S_DONE : S_CALC;
                    end
                    S_DONE: begin
                        r_valid   <= 1'b1;
                        r_rd_addr <= r_addr;
                        r_rd_data <= (r_op == OP_REM || r_op == OP_REMU) ? w_r_fix : w_q_fix;
                        r_state   <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed table plus multi-cycle corner sequences and random ops for div_unit
module tb_div_unit;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_rs1_data = '0;
    logic [31:0] i_rs2_data = '0;
    logic [4:0]  i_rd_addr = '0;
    logic        i_kill = 1'b0;
    logic        o_valid;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    int n_vec = 0;
    int n_bad = 0;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;
    vec_t tbl[20];
    div_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_rd_addr  (i_rd_addr),
        .i_kill     (i_kill),
        .o_valid    (o_valid),
        .o_rd_addr  (o_rd_addr),
        .o_rd_data  (o_rd_data)
    );
    always #5 i_clk = ~i_clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction
    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int k;
        k = 0;
        @(negedge i_clk);
        while (!o_ready && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        i_valid = 1'b1;
        i_op = op;
        i_rs1_data = a;
        i_rs2_data = b;
        i_rd_addr = rd;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat, input bit noise, input string name);
        int k;
        bit busy_ok;
        drive(op, a, b, rd);
        busy_ok = 1'b1;
        for (k = 0; k < 60; k++) begin
            @(negedge i_clk);
            if (o_valid) break;
            if (o_ready) busy_ok = 1'b0;
            if (noise) begin
                i_valid = k[0];
                i_op = 2'($urandom);
                i_rs1_data = $urandom;
                i_rs2_data = $urandom;
                i_rd_addr = 5'($urandom);
            end
        end
        i_valid = 1'b0;
        chk({name, " ready_low"}, 32'(busy_ok), 32'd1);
        chk({name, " latency"}, k, lat);
        chk({name, " data"}, o_rd_data, exp);
        chk({name, " addr"}, 32'(o_rd_addr), 32'(rd));
        @(negedge i_clk);
        chk({name, " pulse"}, 32'(o_valid), 32'd0);
        chk({name, " ready_after"}, 32'(o_ready), 32'd1);
    endtask
    task automatic count_valid(input int cycles, output int nv);
        nv = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge i_clk);
            if (o_valid) nv++;
        end
    endtask
    initial begin
        int nv;
        tbl[0]  = '{2'b00, 32'd20,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFFA, 33, "div_20_m3"};
        tbl[1]  = '{2'b10, 32'd20,         32'hFFFF_FFFD, 5'd2,  32'h0000_0002, 33, "rem_20_m3"};
        tbl[2]  = '{2'b10, 32'hFFFF_FFEC,  32'd3,         5'd3,  32'hFFFF_FFFE, 33, "rem_m20_3"};
        tbl[3]  = '{2'b01, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'h7FFF_FFFF, 33, "divu_max_2"};
        tbl[4]  = '{2'b11, 32'hFFFF_FFFF,  32'd2,         5'd5,  32'h0000_0001, 33, "remu_max_2"};
        tbl[5]  = '{2'b00, 32'd7,          32'd0,         5'd6,  32'hFFFF_FFFF, 1,  "div_7_0"};
        tbl[6]  = '{2'b10, 32'd7,          32'd0,         5'd7,  32'h0000_0007, 1,  "rem_7_0"};
        tbl[7]  = '{2'b01, 32'd0,          32'd0,         5'd8,  32'hFFFF_FFFF, 1,  "divu_0_0"};
        tbl[8]  = '{2'b10, 32'hFFFF_FFFB,  32'd0,         5'd9,  32'hFFFF_FFFB, 1,  "rem_m5_0"};
        tbl[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1,  "div_ovf"};
        tbl[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1,  "rem_ovf"};
        tbl[11] = '{2'b01, 32'd0,          32'd5,         5'd0,  32'h0000_0000, 33, "divu_0_5_rd0"};
        tbl[12] = '{2'b00, 32'hFFFF_FFF9,  32'd2,         5'd12, 32'hFFFF_FFFD, 33, "div_m7_2"};
        tbl[13] = '{2'b10, 32'hFFFF_FFF9,  32'd2,         5'd13, 32'hFFFF_FFFF, 33, "rem_m7_2"};
        tbl[14] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 33, "divu_min_max"};
        tbl[15] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 33, "remu_min_max"};
        tbl[16] = '{2'b00, 32'h8000_0000,  32'd1,         5'd16, 32'h8000_0000, 33, "div_min_1"};
        tbl[17] = '{2'b11, 32'd1000,       32'd7,         5'd17, 32'h0000_0006, 33, "remu_1000_7"};
        tbl[18] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 5'd18, 32'h0000_000E, 33, "div_m100_m7"};
        tbl[19] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 5'd19, 32'hFFFF_FFFE, 33, "rem_m100_m7"};
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset valid", 32'(o_valid), 32'd0);
        chk("reset data", o_rd_data, 32'd0);
        chk("reset addr", 32'(o_rd_addr), 32'd0);
        chk("reset ready", 32'(o_ready), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("ready after reset", 32'(o_ready), 32'd1);
        for (int i = 0; i < 20; i++)
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].lat, 1'b0, tbl[i].name);
        drive(2'b01, 32'd100, 32'd7, 5'd3);
        repeat (11) @(negedge i_clk);
        i_kill = 1'b1;
        @(negedge i_clk);
        i_kill = 1'b0;
        chk("kill ready", 32'(o_ready), 32'd1);
        count_valid(40, nv);
        chk("kill no valid", nv, 0);
        do_op(2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 33, 1'b0, "divu_after_kill");
        drive(2'b00, 32'd7, 32'd0, 5'd4);
        i_kill = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        nv = o_valid ? 1 : 0;
        i_kill = 1'b0;
        chk("kill vs done", nv, 0);
        i_valid = 1'b1;
        i_kill = 1'b1;
        i_op = 2'b01;
        i_rs1_data = 32'd9;
        i_rs2_data = 32'd3;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_kill = 1'b0;
        chk("kill blocks accept", 32'(o_ready), 32'd1);
        count_valid(40, nv);
        chk("kill blocks valid", nv, 0);
        drive(2'b00, 32'd20, 32'hFFFF_FFFD, 5'd9);
        repeat (5) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("midrst valid", 32'(o_valid), 32'd0);
        chk("midrst data", o_rd_data, 32'd0);
        chk("midrst addr", 32'(o_rd_addr), 32'd0);
        chk("midrst ready", 32'(o_ready), 32'd0);
        i_rst = 1'b0;
        #1;
        chk("midrst ready after", 32'(o_ready), 32'd1);
        count_valid(40, nv);
        chk("midrst no valid", nv, 0);
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  rd;
            int          lat;
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 7 == 0) b = 32'd0;
            if (i % 8 == 5) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            rd = (i % 5 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lat = (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
            do_op(op, a, b, rd, ref_res(op, a, b), lat, i[0], $sformatf("rand%0d", i));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
